// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter slice.
// The burst-lock feature is compiled in with MULT_ARB_LOCK_EN.
package mult_arb_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/Multiplier_top.sv
// Combinational signed DATA_W x DATA_W multiplier shared by the arbiter.
// The product is exact at 2*DATA_W bits.
module Multiplier_top
    import mult_arb_pkg::*;
(
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    output logic signed [2*DATA_W-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: the requester right after last_i has the
// highest priority, and last_i itself has the lowest.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int cand;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = N; k >= 1; k--) begin
            cand = (int'(last_i) + k) % N;
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ requesters.
// Define MULT_ARB_LOCK_EN to let a requester hold the multiplier for a burst.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = idWidth(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*DATA_W-1:0]       res_data,
    output logic [IDW-1:0]            res_id
);

    arb_state_e                 state_q, state_d;
    logic signed [DATA_W-1:0]   opA_q, opA_d, opB_q, opB_d;
    logic [IDW-1:0]             id_q, id_d, lastGrant_q, lastGrant_d;
    logic [IDW-1:0]             resId_q, resId_d;
    logic [2*DATA_W-1:0]        resData_q, resData_d;
    logic                       resValid_q, resValid_d;
    logic [NUM_REQ-1:0]         pickReq, grant;
    logic [IDW-1:0]             pickIdx;
    logic                       pickAny;
    logic signed [2*DATA_W-1:0] product;

`ifdef MULT_ARB_LOCK_EN
    logic           locked_q, locked_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           ownerValid;

    assign ownerValid = req_valid[owner_q];

    // A held lock narrows the candidate set to the owner as long as it keeps asking.
    always_comb begin
        pickReq = req_valid;
        if (locked_q && ownerValid) begin
            pickReq          = '0;
            pickReq[owner_q] = 1'b1;
        end
    end

    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        if (state_q == IDLE) begin
            if (locked_q && !ownerValid) begin
                locked_d = 1'b0;
            end
            if (pickAny) begin
                locked_d = req_lock[pickIdx];
                owner_d  = pickIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= 1'b0;
            owner_q  <= '0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
        end
    end
`else
    logic unusedLock;

    assign unusedLock = ^req_lock;
    assign pickReq    = req_valid;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .req_i   (pickReq),
        .last_i  (lastGrant_q),
        .grant_o (grant),
        .idx_o   (pickIdx),
        .any_o   (pickAny)
    );

    Multiplier_top u_mult (
        .a_i (opA_q),
        .b_i (opB_q),
        .p_o (product)
    );

    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign res_valid = resValid_q;
    assign res_data  = resData_q;
    assign res_id    = resId_q;

    always_comb begin
        state_d     = state_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        id_d        = id_q;
        lastGrant_d = lastGrant_q;
        resData_d   = resData_q;
        resId_d     = resId_q;
        resValid_d  = resValid_q;
        unique case (state_q)
            IDLE: begin
                if (pickAny) begin
                    opA_d       = req_a[pickIdx*DATA_W +: DATA_W];
                    opB_d       = req_b[pickIdx*DATA_W +: DATA_W];
                    id_d        = pickIdx;
                    lastGrant_d = pickIdx;
                    state_d     = CALC;
                end
            end
            CALC: begin
                resData_d  = product;
                resId_d    = id_q;
                resValid_d = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    resValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset starts with the last grant at the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            id_q        <= '0;
            lastGrant_q <= IDW'(NUM_REQ - 1);
            resData_q   <= '0;
            resId_q     <= '0;
            resValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            id_q        <= id_d;
            lastGrant_q <= lastGrant_d;
            resData_q   <= resData_d;
            resId_q     <= resId_d;
            resValid_q  <= resValid_d;
        end
    end

endmodule
